fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end with a decoupling prefetch queue, sitting between the program ROM and the decode stage of the pipelined RV32IM core. It owns the fetch PC, fetches one word per cycle while space remains, and buffers instructions as {pc, inst} entries in a circular queue. Decode drains the queue with a valid/ready handshake, which lets decode stall without throttling the ROM. An execute-stage redirect flushes the queue and restarts fetch at the target.

## Interface
- Parameters:
  - `XLEN`, 32: address/data width.
  - `DEPTH`, 4: queue entries; power of two, ≥2.
  - `RESET_PC`, 0: fetch PC after reset.
- Ports (clock and reset first):
  - `clk`  in  1  single clock, all state updates on rising edge.
  - `rst`  in  1  synchronous, active-high reset.
  - `imem_addr`  out  XLEN  current fetch PC, driven to the program ROM.
  - `imem_data`  in  32  instruction word at `imem_addr`, same cycle.
  - `imem_valid`  in  1  `imem_data` valid this cycle; 0 = ROM wait.
  - `redirect_valid`  in  1  taken branch/jump resolved in EX.
  - `redirect_pc`  in  XLEN  redirect target.
  - `deq_valid`  out  1  queue head holds an instruction.
  - `deq_ready`  in  1  decode accepts the head this cycle.
  - `deq_inst`  out  32  head instruction; 32'h13 (NOP) when empty.
  - `deq_pc`  out  XLEN  head PC; 0 when empty.
  - `deq_pred_taken`  out  1  fetch predicted this entry taken.
  - `occupancy`  out  $clog2(DEPTH)+1  entries held.

## Operation
- Reset: PC ← `RESET_PC`, read/write pointers ← 0, count ← 0. Outputs: `deq_valid`=0, `deq_inst`=32'h13, `deq_pc`=0, `deq_pred_taken`=0, `occupancy`=0.
- Push condition: `imem_valid` & (count<DEPTH | pop). On push, write {PC, `imem_data`, pred} at wptr, wptr+1 mod DEPTH, and PC ← next PC.
- Next PC: PC+4, or the predicted target (see Configuration). Arithmetic is modulo 2^XLEN, so 0xFFFF_FFFC+4 wraps to 0.
- Pop: `deq_valid` & `deq_ready`; rptr+1 mod DEPTH.
- Count: +1 on push only, −1 on pop only, unchanged on both. When full, a simultaneous push and pop is legal and keeps full throughput.
- No ROM stall: when `imem_valid`=0, PC holds and nothing is pushed.
- Redirect has priority over everything:
  - pointers and count ← 0;
  - the fetch that cycle is discarded;
  - a pop the same cycle is ignored, and decode must treat the head as squashed;
  - PC ← {`redirect_pc`[XLEN-1:1], 1'b0}.
- Reset has priority over redirect.
- Head outputs are registered-array reads of rptr, so no combinational path runs from `imem_data` to `deq_*`.

## Timing
- Fetch-to-decode latency is 1 cycle: a word pushed at edge N is visible on `deq_*` after edge N. There is no empty-queue bypass.
- Redirect at cycle t:
  - queue empty at t+1;
  - `imem_addr`=target at t+1;
  - target instruction on `deq_*` at t+2.
- Steady state: one instruction per cycle when `imem_valid` and `deq_ready` are both held high.
- `occupancy` reflects post-edge state.

## Configuration
- Macro: `FETCH_STATIC_PREDICT_EN`.
- Defined:
  - JAL (opcode 7'b1101111): next PC = PC + J-imm.
  - B-type (7'b1100011) with a negative immediate: next PC = PC + B-imm.
  - Each such entry stores pred=1.
  - Mispredicts are corrected by EX via the redirect interface.
- Undefined: next PC is always PC+4, `deq_pred_taken` is tied to 0, and the predecode logic is absent.

## Structure
- Package `fetch_pkg`:
  - `NOP_INST` = 32'h13;
  - opcode constants `OP_JAL` and `OP_BRANCH`;
  - typedef `fq_entry_t` {pc, inst, pred}.
- Sub-module `fetch_predecode`, purely combinational: inst, pc → pred_taken, pred_target (J/B immediate sign-extension). It is instantiated only under the macro.

## Test plan
- Reset, `imem_valid`=1, `deq_ready`=0 for 6 cycles → pushes at PC 0,4,8,12; `occupancy`=4; `imem_addr` holds 16; `deq_pc`=0.
- Full queue, `deq_ready`=1 continuously → one pop and one push per cycle, `occupancy` stays 4, `deq_pc` sequence 0,4,8,…
- Redirect to 0x101 while `occupancy`=3 with `deq_ready`=1 → `occupancy` 0 and `deq_valid`=0 at t+1, `imem_addr`=0x100, `deq_pc`=0x100 at t+2.
- `imem_valid` toggling 1,0,1 → only 2 entries pushed, PC advances by 8.
- `RESET_PC`=0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- With macro defined: JAL imm=+0x40 at PC 8 → next `imem_addr`=0x48 and entry `deq_pred_taken`=1. BEQ imm=+8 → no prediction.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch-queue entry type for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned FQ_XLEN = 32;
  localparam int unsigned ILEN    = 32;

  localparam logic [ILEN-1:0] NOP_INST  = 32'h0000_0013;
  localparam logic [6:0]      OP_JAL    = 7'b1101111;
  localparam logic [6:0]      OP_BRANCH = 7'b1100011;

  // One buffered fetch: its PC, the raw word and whether fetch steered past it.
  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [ILEN-1:0]    inst;
    logic               pred;
  } fq_entry_t;

endpackage

// File: rtl/fetch_predecode.sv
// Static predictor: JAL always taken, backward conditional branches taken.
// Purely combinational; only instantiated when FETCH_STATIC_PREDICT_EN is defined.
module fetch_predecode
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [20:0]     j_imm;
  logic [12:0]     b_imm;
  logic [XLEN-1:0] offset;
  logic            is_jal;
  logic            is_bwd_branch;

  always_comb begin
    j_imm         = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm         = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    is_jal        = (inst[6:0] == OP_JAL);
    // A set sign bit means the branch points backwards, typically a loop.
    is_bwd_branch = (inst[6:0] == OP_BRANCH) && inst[31];
    offset        = is_jal ? XLEN'($signed(j_imm)) : XLEN'($signed(b_imm));
    pred_taken    = is_jal || is_bwd_branch;
    pred_target   = pc + offset;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC owner plus circular prefetch queue feeding decode over valid/ready.
// Static prediction is enabled by defining FETCH_STATIC_PREDICT_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [XLEN-1:0]         imem_addr,
  input  logic [31:0]             imem_data,
  input  logic                    imem_valid,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [31:0]             deq_inst,
  output logic [XLEN-1:0]         deq_pc,
  output logic                    deq_pred_taken,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fq_entry_t        mem_q [DEPTH];
  fq_entry_t        mem_d [DEPTH];

  fq_entry_t        head;
  logic             push;
  logic             pop;
  logic             pred_taken;
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  next_pc;

  assign seq_pc = pc_q + XLEN'(4);

`ifdef FETCH_STATIC_PREDICT_EN
  logic [XLEN-1:0] pred_target;

  fetch_predecode #(.XLEN(XLEN)) u_predecode (
    .inst        (imem_data),
    .pc          (pc_q),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  assign next_pc = pred_taken ? pred_target : seq_pc;
`else
  assign pred_taken = 1'b0;
  assign next_pc    = seq_pc;
`endif

  // Head view is read straight from the storage flops; nothing from imem_data reaches it.
  assign head           = mem_q[rptr_q];
  assign deq_valid      = (count_q != '0);
  assign deq_inst       = deq_valid ? head.inst : NOP_INST;
  assign deq_pc         = deq_valid ? XLEN'(head.pc) : '0;
  assign deq_pred_taken = deq_valid && head.pred;
  assign imem_addr      = pc_q;
  assign occupancy      = count_q;

  assign pop  = deq_valid && deq_ready;
  assign push = imem_valid && ((count_q < CNT_W'(DEPTH)) || pop);

  // Next-state: redirect squashes the queue and any fetch or pop in the same cycle.
  always_comb begin
    pc_d    = pc_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~XLEN'(1);
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = '{pc: FQ_XLEN'(pc_q), inst: imem_data, pred: pred_taken};
        wptr_d        = wptr_q + PTR_W'(1);
        pc_d          = next_pc;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based reference model predicts handshakes
// and per-cycle state; an independent monitor compares what the DUT presents.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        imem_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic        deq_pred_taken;
  logic [2:0]  occupancy;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_valid     (imem_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_inst       (deq_inst),
    .deq_pc         (deq_pc),
    .deq_pred_taken (deq_pred_taken),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_ent_t;

  typedef struct {
    int          occ;
    logic [31:0] addr;
  } cyc_chk_t;

  exp_ent_t    mq[$];      // model of queue contents
  exp_ent_t    exp_q[$];   // expected handshakes, in order
  cyc_chk_t    chk_q[$];   // expected per-cycle occupancy / fetch address
  logic [31:0] m_pc = 32'h0;
  bit          known = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ 32'h7F4A_7C15;
    case (h[3:0])
      4'd0:    return {h[31:7], 7'b1101111};
      4'd1:    return {h[31:7], 7'b1100011};
      default: return {h[31:7], 7'b0010011};
    endcase
  endfunction

  // Where fetch goes after pc holding inst, and whether it predicted a taken transfer.
  function automatic void model_fetch(input logic [31:0] pc, input logic [31:0] inst,
                                      output logic pred, output logic [31:0] nxt);
    int off;
    pred = 1'b0;
    nxt  = pc + 32'd4;
    off  = 0;
`ifdef FETCH_STATIC_PREDICT_EN
    if (inst[6:0] == 7'b1101111) begin
      off  = int'({inst[19:12], 12'b0}) + int'({inst[20], 11'b0}) + int'({inst[30:21], 1'b0})
             - (inst[31] ? (1 << 20) : 0);
      pred = 1'b1;
      nxt  = pc + 32'(off);
    end else if (inst[6:0] == 7'b1100011 && inst[31]) begin
      off  = int'({inst[7], 11'b0}) + int'({inst[30:25], 5'b0}) + int'({inst[11:8], 1'b0}) - 4096;
      pred = 1'b1;
      nxt  = pc + 32'(off);
    end
`endif
  endfunction

  // Drive one cycle of inputs at the falling edge and advance the model across the next rising edge.
  task automatic step(input logic r, input logic iv, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    exp_ent_t    e;
    logic        pred;
    logic [31:0] nxt;
    bit          do_pop, do_push;
    @(negedge clk);
    if (known) chk_q.push_back('{occ: mq.size(), addr: m_pc});
    rst            = r;
    imem_valid     = iv;
    redirect_valid = rv;
    redirect_pc    = rpc;
    deq_ready      = rdy;
    imem_data      = rom_word(m_pc);
    if (r) begin
      mq.delete();
      m_pc  = RESET_PC;
      known = 1'b1;
    end else if (rv) begin
      mq.delete();
      m_pc = {rpc[31:1], 1'b0};
    end else begin
      do_pop  = (mq.size() > 0) && rdy;
      do_push = iv && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) exp_q.push_back(mq.pop_front());
      if (do_push) begin
        model_fetch(m_pc, imem_data, pred, nxt);
        e = '{pc: m_pc, inst: imem_data, pred: pred};
        mq.push_back(e);
        m_pc = nxt;
      end
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle state and every accepted head, compared against the model's expectations.
  initial begin
    cyc_chk_t c;
    exp_ent_t e;
    forever begin
      @(negedge clk);
      #1;
      if (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        check("occupancy", 32'(occupancy), 32'(c.occ));
        check("imem_addr", imem_addr, c.addr);
        check("deq_valid", 32'(deq_valid), 32'(c.occ != 0));
        if (c.occ == 0) begin
          check("empty_inst", deq_inst, 32'h13);
          check("empty_pc", deq_pc, 32'h0);
          check("empty_pred", 32'(deq_pred_taken), 32'h0);
        end
      end
      if (!rst && !redirect_valid && deq_valid && deq_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop_pc", deq_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("deq_pc", deq_pc, e.pc);
          check("deq_inst", deq_inst, e.inst);
          check("deq_pred", 32'(deq_pred_taken), 32'(e.pred));
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    // Reset, then fill with decode stalled.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    after_edge();
    check("fill_occ", 32'(occupancy), 32'd4);
    check("fill_addr", imem_addr, 32'd16);
    check("fill_head_pc", deq_pc, 32'd0);

    // Full queue at full throughput.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    after_edge();
    check("stream_occ", 32'(occupancy), 32'd4);

    // Drop to 3, then redirect to an odd target with decode ready.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    after_edge();
    check("pre_redir_occ", 32'(occupancy), 32'd3);
    step(1'b0, 1'b1, 1'b1, 32'h101, 1'b1);
    after_edge();
    check("redir_occ", 32'(occupancy), 32'd0);
    check("redir_valid", 32'(deq_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    after_edge();
    check("redir_head_pc", deq_pc, 32'h100);

    // ROM wait in the middle of a burst.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    after_edge();
    check("toggle_occ", 32'(occupancy), 32'd3);
    check("toggle_addr", imem_addr, 32'h10C);

    // PC wraps past the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    after_edge();
    check("wrap_occ", 32'(occupancy), 32'd3);
    check("wrap_head_pc", deq_pc, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic with ROM waits, decode stalls, redirects and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      step(1'b0 || ($urandom_range(0, 199) == 0),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0,
           rpc,
           $urandom_range(0, 2) != 0);
    end

    // Drain and confirm every expected handshake was seen.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #2;
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
